// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the Y86-64 instruction-memory responder:
//   - icode constants for the valid Y86-64 instruction classes
//   - INSTR_BYTES, the width of the packed instruction word in bytes
//   - y86_instr_len(), the instruction length implied by an icode
//   - resp_state_t, the responder state encoding
// -----------------------------------------------------------------------------
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_CMOVXX = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam int INSTR_BYTES = 10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_OPCODE,
      S_BODY,
      S_RESP
   } resp_state_t;

   // Length in bytes of the instruction whose opcode byte carries this icode.
   // Undefined icodes (C..F) are treated as one byte; flagging them as illegal
   // is left to the core's decode stage.
   function automatic logic [3:0] y86_instr_len(input logic [3:0] icode);
      logic [3:0] len;
      len = 4'd1;
      case (icode)
         I_HALT, I_NOP, I_RET:                len = 4'd1;
         I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ:    len = 4'd2;
         I_JXX, I_CALL:                       len = 4'd9;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:        len = 4'd10;
         default:                             len = 4'd1;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/y86_byte_ram.sv
// -----------------------------------------------------------------------------
// y86_byte_ram
// MEM_BYTES x 8 instruction store. Combinational read, registered write, so a
// read of the address being written in the same cycle returns the old byte.
// Writes to addresses at or beyond MEM_BYTES are dropped.
// Ports:
//   clock    in   system clock
//   we       in   write enable
//   wr_addr  in   write address (AW bits)
//   wr_data  in   write byte
//   rd_addr  in   read address (AW bits)
//   rd_data  out  read byte (0 for an address outside the store)
// -----------------------------------------------------------------------------
module y86_byte_ram #(
   parameter int MEM_BYTES = 1024,
   parameter int AW        = 10
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [MEM_BYTES];

   always_ff @(posedge clock) begin
      if (we && (int'(wr_addr) < MEM_BYTES)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Guard keeps a non-power-of-two store from indexing past its end.
   assign rd_data = (int'(rd_addr) < MEM_BYTES) ? mem[rd_addr] : 8'h00;

endmodule

// File: rtl/y86_imem_responder.sv
// -----------------------------------------------------------------------------
// y86_imem_responder
// Instruction-memory responder for the SEQ Y86-64 core. Accepts a fetch PC,
// reads the opcode byte, derives the instruction length from icode, then reads
// the remaining bytes one per cycle and presents a packed 10-byte word.
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   req_valid/req_ready   fetch request handshake (ready only in IDLE)
//   req_pc                fetch address, 64 bits
//   rsp_valid/rsp_ready   response handshake; response held until accepted
//   rsp_instr             byte i at [8i+7:8i], unread bytes zero
//   rsp_len               number of bytes actually fetched, 0..10
//   rsp_imem_error        some instruction byte lay outside the store
//   load_en/addr/data     byte-wide store fill port, usable in any state
// -----------------------------------------------------------------------------
module y86_imem_responder
   import y86_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int AW        = 10
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [63:0]   req_pc,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [79:0]   rsp_instr,
   output logic [3:0]    rsp_len,
   output logic          rsp_imem_error,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [7:0]    load_data
);

   localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);

   resp_state_t state, state_nxt;

   logic [63:0]                  pc;
   logic [3:0]                   cnt;
   logic [3:0]                   target;
   logic                         err;
   logic [INSTR_BYTES-1:0][7:0]  instr_buf;

   logic [64:0]   fetch_addr;
   logic          fetch_oob;
   logic          req_oob;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic [3:0]    len_lookup;

   // Address of the next byte, kept 65 bits wide so pc+cnt never wraps
   // back into the store near the top of the 64-bit space.
   assign fetch_addr = {1'b0, pc} + 65'(cnt);
   assign fetch_oob  = (fetch_addr >= MEM_LIMIT);
   assign req_oob    = ({1'b0, req_pc} >= MEM_LIMIT);
   assign rd_addr    = fetch_addr[AW-1:0];
   assign len_lookup = y86_instr_len(rd_data[7:4]);

   y86_byte_ram #(
      .MEM_BYTES (MEM_BYTES),
      .AW        (AW)
   ) u_ram (
      .clock   (clock),
      .we      (load_en),
      .wr_addr (load_addr),
      .wr_data (load_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nxt = req_oob ? S_RESP : S_OPCODE;
            end
         end
         S_OPCODE: begin
            state_nxt = (len_lookup == 4'd1) ? S_RESP : S_BODY;
         end
         S_BODY: begin
            // Running off the end of the store ends the fetch early.
            if (fetch_oob || ((cnt + 4'd1) == target)) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         pc        <= 64'd0;
         cnt       <= 4'd0;
         target    <= 4'd0;
         err       <= 1'b0;
         instr_buf <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  pc        <= req_pc;
                  cnt       <= 4'd0;
                  target    <= 4'd0;
                  err       <= req_oob;
                  instr_buf <= '0;
               end
            end
            S_OPCODE: begin
               instr_buf[0] <= rd_data;
               cnt          <= 4'd1;
               target       <= len_lookup;
            end
            S_BODY: begin
               if (fetch_oob) begin
                  err <= 1'b1;
               end else begin
                  instr_buf[cnt] <= rd_data;
                  cnt            <= cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_instr      = instr_buf;
   assign rsp_len        = cnt;
   assign rsp_imem_error = err;

endmodule

// File: tb/tb_y86_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_y86_imem_responder
// Directed bench for the instruction-memory responder: a table of fetch
// vectors with hand-computed results, plus hand-written sequences for the
// response stall and the mid-fetch reset.
// -----------------------------------------------------------------------------
module tb_y86_imem_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [63:0] req_pc = 64'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [79:0] rsp_instr;
   logic [3:0]  rsp_len;
   logic        rsp_imem_error;
   logic        load_en = 1'b0;
   logic [9:0]  load_addr = 10'd0;
   logic [7:0]  load_data = 8'd0;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   y86_imem_responder #(.MEM_BYTES(1024), .AW(10)) dut (
      .clock          (clock),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_pc         (req_pc),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_instr      (rsp_instr),
      .rsp_len        (rsp_len),
      .rsp_imem_error (rsp_imem_error),
      .load_en        (load_en),
      .load_addr      (load_addr),
      .load_data      (load_data)
   );

   typedef struct {
      string       name;
      logic [63:0] pc;
      logic [79:0] instr;
      logic [3:0]  len;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic load_byte(input logic [9:0] a, input logic [7:0] d);
      @(negedge clock);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(posedge clock);
      #1;
      load_en = 1'b0;
   endtask

   // Issues one request; returns once rsp_valid is seen (or the bound expires),
   // leaving the response unaccepted. lat counts cycles after the accept edge.
   task automatic issue(input logic [63:0] pc, output int lat);
      @(negedge clock);
      req_pc    = pc;
      req_valid = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 30) begin
         @(posedge clock);
         #1;
         lat++;
      end
   endtask

   task automatic accept_rsp();
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic run_vec(input int i);
      int lat;
      issue(vecs[i].pc, lat);
      chk({vecs[i].name, " valid"}, 80'(rsp_valid), 80'd1);
      chk({vecs[i].name, " latency"}, 80'(lat), 80'(vecs[i].lat));
      chk({vecs[i].name, " instr"}, rsp_instr, vecs[i].instr);
      chk({vecs[i].name, " len"}, 80'(rsp_len), 80'(vecs[i].len));
      chk({vecs[i].name, " error"}, 80'(rsp_imem_error), 80'(vecs[i].err));
      accept_rsp();
      chk({vecs[i].name, " ready after"}, 80'(req_ready), 80'd1);
   endtask

   initial begin
      logic [79:0] held;
      logic [7:0]  irmov [10];
      int          lat;

      vecs[0] = '{"irmovq", 64'd0,    80'h0000000000000008F330, 4'd10, 1'b0, 11};
      vecs[1] = '{"addq",   64'd20,   80'h0360,                 4'd2,  1'b0, 3};
      vecs[2] = '{"halt",   64'd5,    80'h00,                   4'd1,  1'b0, 2};
      vecs[3] = '{"invalid",64'd6,    80'hF0,                   4'd1,  1'b0, 2};
      vecs[4] = '{"jmp_edge",64'd1020,80'h33221170,             4'd4,  1'b1, 6};
      vecs[5] = '{"pc_max", 64'hFFFF_FFFF_FFFF_FFFF, 80'h0,     4'd0,  1'b1, 1};

      irmov = '{8'h30, 8'hF3, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      chk("reset rsp_valid", 80'(rsp_valid), 80'd0);
      chk("reset req_ready", 80'(req_ready), 80'd1);
      chk("reset rsp_instr", rsp_instr, 80'd0);
      chk("reset rsp_len", 80'(rsp_len), 80'd0);
      chk("reset error", 80'(rsp_imem_error), 80'd0);

      for (int i = 0; i < 10; i++) load_byte(10'(i), irmov[i]);
      load_byte(10'd20, 8'h60);
      load_byte(10'd21, 8'h03);
      for (int i = 0; i < 2; i++) run_vec(i);

      load_byte(10'd5, 8'h00);
      load_byte(10'd6, 8'hF0);
      load_byte(10'd1020, 8'h70);
      load_byte(10'd1021, 8'h11);
      load_byte(10'd1022, 8'h22);
      load_byte(10'd1023, 8'h33);
      for (int i = 2; i < 6; i++) run_vec(i);

      // Response held while the consumer stalls; a request during RESP is ignored.
      issue(64'd20, lat);
      chk("stall valid", 80'(rsp_valid), 80'd1);
      held = rsp_instr;
      req_pc    = 64'd0;
      req_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clock);
         #1;
         chk("stall rsp_valid", 80'(rsp_valid), 80'd1);
         chk("stall instr", rsp_instr, held);
         chk("stall instr value", rsp_instr, 80'h0360);
         chk("stall req_ready", 80'(req_ready), 80'd0);
      end
      req_valid = 1'b0;
      accept_rsp();
      chk("post-stall req_ready", 80'(req_ready), 80'd1);
      chk("post-stall rsp_valid", 80'(rsp_valid), 80'd0);

      // Reset during the body of a 10-byte fetch aborts it.
      @(negedge clock);
      req_pc    = 64'd0;
      req_valid = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      chk("abort rsp_valid", 80'(rsp_valid), 80'd0);
      chk("abort req_ready", 80'(req_ready), 80'd1);
      run_vec(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
